quadrature_encoder_emulator: RTL and testbench
==============================================

// Module: quadrature_encoder_emulator
// PURPOSE
//   Generates incremental-encoder A/B/Z waveforms from step commands. It drives the
//   encoder inputs of the servo QEI for loopback, bring-up and hardware-in-loop tests
//   without a motor. It sits beside the PWM and QEI peripherals in the servo FPGA.
//   Commands arrive over a valid/ready handshake; each command is a signed step count
//   plus an edge period.
// PARAMETERS
//   STEP_W    16    width of signed cmd_steps
//   PERIOD_W  16    width of unsigned cmd_period (clk cycles per quadrature edge)
//   POS_W     32    width of signed position counter
//   CPR       2000  quadrature counts per revolution (index period); must be >=4
// PORTS
//   clk         in   1         system clock; all logic on rising edge
//   reset_n     in   1         synchronous, active-low reset
//   cmd_valid   in   1         command present
//   cmd_ready   out  1         block can accept command (high only in IDLE)
//   cmd_steps   in   STEP_W    signed edge count; >0 forward, <0 reverse
//   cmd_period  in   PERIOD_W  clk cycles between edges; 0 treated as 1
//   abort       in   1         stop current command
//   enc_a       out  1         quadrature channel A (registered)
//   enc_b       out  1         quadrature channel B (registered)
//   enc_z       out  1         index pulse (registered)
//   busy        out  1         high in RUN
//   done        out  1         one-cycle pulse when a command completes normally
//   position    out  POS_W     signed count of emitted edges, +1 fwd / -1 rev
// BEHAVIOUR
//   - Reset (reset_n=0 at a clk edge): state=IDLE, phase=00, enc_a=0, enc_b=0,
//     position=0, angle=0, busy=0, done=0, cmd_ready=1 on the next cycle.
//     enc_z=1 if QENC_INDEX_EN is defined, else 0. Reset mid-RUN discards the command.
//   - States: IDLE -> RUN on accept (cmd_valid & cmd_ready) with cmd_steps!=0.
//     If cmd_steps==0: no edges; done pulses in the cycle after accept; stay in IDLE.
//   - On accept: remaining=|cmd_steps|; dir=sign; timer=max(cmd_period,1)-1.
//     |cmd_steps| uses STEP_W bits unsigned, so the most negative value is legal.
//   - RUN: timer decrements each cycle. At timer==0 one edge is emitted and timer reloads.
//     The first edge is registered P cycles after the accept edge (P = effective period),
//     then every P cycles.
//   - Phase sequence, {A,B}: forward 00->10->11->01->00 (A leads B); reverse is the
//     inverse order. Exactly one of A/B changes per edge.
//   - position wraps in two's complement at POS_W.
//   - The final edge (remaining 1->0) returns to IDLE. done=1 for exactly the next cycle,
//     and cmd_ready=1 in the same cycle as that done.
//   - abort in RUN: IDLE next cycle. A/B/Z/position hold their values; no done pulse;
//     no further edges.
//   - abort coinciding with the final edge: the edge is emitted and done pulses
//     (completion wins). abort in IDLE has no effect.
//   - cmd_valid while busy: ignored and not latched (cmd_ready=0).
// CONFIGURATION
//   QENC_INDEX_EN defined:
//     - angle counter 0..CPR-1 advances with each edge. Forward wraps CPR-1->0;
//       reverse wraps 0->CPR-1.
//     - enc_z=1 exactly while angle==0 && phase==00 (one quadrature state wide),
//       registered with A/B.
//   QENC_INDEX_EN undefined:
//     - enc_z tied 0; no angle counter logic.
// TESTING
//   1. Reset, then steps=+4, period=3 -> A/B = 10,11,01,00 at accept+3/6/9/12;
//      done at +13; position=4.
//   2. steps=-2, period=1 from phase 00 -> A/B = 01 then 11 on consecutive cycles;
//      position=-2; done once.
//   3. steps=0 and steps=+5/period=0 -> first: done next cycle, no edges; second:
//      period behaves as 1, 5 edges.
//   4. steps=+100, period=2; abort at 10th edge -> IDLE next cycle, position=10,
//      no done, A/B frozen.
//   5. With QENC_INDEX_EN, CPR=8: steps=+16 -> enc_z high at position 0, 8, 16 only;
//      steps=-1 from angle 0 -> angle 7, enc_z low.
//   6. cmd_valid held through a 6-edge command, reset_n low mid-RUN ->
//      second command accepted only in the done cycle; reset yields the values above.

Source files
------------

// File: rtl/quadrature_encoder_emulator.sv
// quadrature_encoder_emulator
//   Turns signed step commands into incremental-encoder A/B/Z waveforms so the
//   servo QEI can be exercised without a motor (loopback, bring-up, HIL).
//
//   Optional feature macro: QENC_INDEX_EN
//     defined   - an angle counter (0..CPR-1) follows every edge and enc_z is
//                 high for the single quadrature state where angle==0, phase==00.
//     undefined - enc_z is tied low and no angle logic is built.
//
// Ports
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   cmd_valid/ready     command handshake; ready only while idle
//   cmd_steps           signed edge count (>0 forward, <0 reverse, 0 = no-op)
//   cmd_period          clk cycles per edge (0 behaves as 1)
//   abort               stop the running command, outputs hold
//   enc_a/enc_b/enc_z   registered quadrature outputs
//   busy                command running
//   done                one-cycle pulse on normal completion
//   position            signed count of emitted edges (wraps)
module quadrature_encoder_emulator #(
    parameter int STEP_W   = 16,
    parameter int PERIOD_W = 16,
    parameter int POS_W    = 32,
    parameter int CPR      = 2000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic signed [STEP_W-1:0] cmd_steps,
    input  logic [PERIOD_W-1:0]      cmd_period,
    input  logic                     abort,
    output logic                     enc_a,
    output logic                     enc_b,
    output logic                     enc_z,
    output logic                     busy,
    output logic                     done,
    output logic signed [POS_W-1:0]  position
);

    if (CPR < 4) begin : g_cpr_check
        $error("CPR must be at least 4");
    end

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                   state, state_nxt;
    logic [STEP_W-1:0]        remaining, remaining_nxt;
    logic                     dir, dir_nxt;          // 1 = forward
    logic [PERIOD_W-1:0]      timer, timer_nxt;
    logic [PERIOD_W-1:0]      reload, reload_nxt;    // effective period - 1
    logic [1:0]               qidx, qidx_nxt;
    logic signed [POS_W-1:0]  position_nxt;
    logic                     done_nxt;

    logic                     accept;
    logic                     tail;
    logic                     last_edge_due;
    logic                     step;
    logic [STEP_W-1:0]        abs_steps;
    logic [PERIOD_W-1:0]      cmd_reload;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);
    assign accept    = cmd_valid && cmd_ready;

    // Magnitude kept unsigned so the most negative step count stays legal.
    assign abs_steps  = cmd_steps[STEP_W-1] ? $unsigned(-cmd_steps) : $unsigned(cmd_steps);
    assign cmd_reload = (cmd_period == '0) ? '0 : cmd_period - PERIOD_W'(1);

    // After the final edge the FSM stays in RUN for one cycle with remaining==0;
    // that cycle produces the done pulse together with the return to IDLE.
    assign tail          = (state == S_RUN) && (remaining == '0);
    assign last_edge_due = (timer == '0) && (remaining == STEP_W'(1));
    // abort suppresses an edge unless it is the final one (completion wins).
    assign step          = (state == S_RUN) && (remaining != '0) && (timer == '0) &&
                           (!abort || (remaining == STEP_W'(1)));

    // State register and all datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            dir       <= 1'b1;
            timer     <= '0;
            reload    <= '0;
            qidx      <= 2'd0;
            position  <= '0;
            done      <= 1'b0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            dir       <= dir_nxt;
            timer     <= timer_nxt;
            reload    <= reload_nxt;
            qidx      <= qidx_nxt;
            position  <= position_nxt;
            done      <= done_nxt;
            // Phase index 0..3 walks {A,B} = 00,10,11,01: B is the MSB and A the
            // XOR of both bits, so a +/-1 index step flips exactly one channel.
            enc_a     <= qidx_nxt[1] ^ qidx_nxt[0];
            enc_b     <= qidx_nxt[1];
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && (abs_steps != '0)) state_nxt = S_RUN;
            S_RUN: begin
                if (tail)                         state_nxt = S_IDLE;
                else if (abort && !last_edge_due) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath / output next values.
    always_comb begin
        remaining_nxt = remaining;
        dir_nxt       = dir;
        timer_nxt     = timer;
        reload_nxt    = reload;
        qidx_nxt      = qidx;
        position_nxt  = position;
        done_nxt      = 1'b0;

        if (accept) begin
            remaining_nxt = abs_steps;
            dir_nxt       = !cmd_steps[STEP_W-1];
            reload_nxt    = cmd_reload;
            timer_nxt     = cmd_reload;
            if (abs_steps == '0) done_nxt = 1'b1;
        end

        if (tail) done_nxt = 1'b1;

        if ((state == S_RUN) && (remaining != '0))
            timer_nxt = (timer == '0) ? reload : timer - PERIOD_W'(1);

        if (step) begin
            remaining_nxt = remaining - STEP_W'(1);
            qidx_nxt      = dir ? qidx + 2'd1 : qidx - 2'd1;
            position_nxt  = dir ? position + POS_W'(1) : position - POS_W'(1);
        end
    end

`ifdef QENC_INDEX_EN
    localparam int AW = $clog2(CPR);

    logic [AW-1:0] angle, angle_nxt;

    always_comb begin
        angle_nxt = angle;
        if (step) begin
            if (dir) angle_nxt = (angle == AW'(CPR - 1)) ? '0 : angle + AW'(1);
            else     angle_nxt = (angle == '0) ? AW'(CPR - 1) : angle - AW'(1);
        end
    end

    // Index is registered from the same next values as A/B so all three align.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            angle <= '0;
            enc_z <= 1'b1;
        end else begin
            angle <= angle_nxt;
            enc_z <= (angle_nxt == '0) && (qidx_nxt == 2'd0);
        end
    end
`else
    assign enc_z = 1'b0;
`endif

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Scoreboard bench for quadrature_encoder_emulator. Expected edge/done events
// (phase, position, index, cycle of appearance) are queued when a command is
// issued; a negedge monitor pops one entry whenever A/B change or done pulses.
// Phase and index are derived from absolute position since reset:
// {A,B} = table[pos mod 4], index high iff pos mod CPR == 0 (index build).
module tb_quadrature_encoder_emulator;
`ifdef QENC_INDEX_EN
    localparam int CPR = 8;
    localparam bit IDX = 1'b1;
`else
    localparam int CPR = 2000;
    localparam bit IDX = 1'b0;
`endif
    localparam int STEP_W   = 16;
    localparam int PERIOD_W = 16;
    localparam int POS_W    = 32;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     cmd_valid = 1'b0;
    logic                     abort = 1'b0;
    logic signed [STEP_W-1:0] cmd_steps = '0;
    logic [PERIOD_W-1:0]      cmd_period = '0;
    logic                     cmd_ready, enc_a, enc_b, enc_z, busy, done;
    logic signed [POS_W-1:0]  position;

    quadrature_encoder_emulator #(
        .STEP_W(STEP_W), .PERIOD_W(PERIOD_W), .POS_W(POS_W), .CPR(CPR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z), .busy(busy), .done(done),
        .position(position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic       is_done;
        logic [1:0] ab;
        int         pos;
        logic       z;
        int         t;
    } ev_t;

    ev_t  sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    logic [1:0] prev_ab = 2'b00;
    int   exp_pos = 0;

    function automatic logic [1:0] ab_of(int pos);
        case (((pos % 4) + 4) % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic logic z_of(int pos);
        return IDX && ((pos % CPR) == 0);
    endfunction

    task automatic chk(string name, longint got, longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d (cyc %0d)", name, got, exp, cyc);
    endtask

    // Monitor: any A/B change or done pulse must match the head of the queue.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en && (({enc_a, enc_b} != prev_ab) || done)) begin
            n_chk++;
            if (sbq.size() == 0) begin
                $display("FAIL unexpected_event ab=%b done=%b pos=%0d z=%b cyc=%0d",
                         {enc_a, enc_b}, done, position, enc_z, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.is_done === done && e.ab === {enc_a, enc_b} && e.pos == int'(position) &&
                    e.z === enc_z && e.t == cyc)
                    n_pass++;
                else
                    $display("FAIL sb_event got done=%b ab=%b pos=%0d z=%b cyc=%0d exp done=%b ab=%b pos=%0d z=%b cyc=%0d",
                             done, {enc_a, enc_b}, position, enc_z, cyc,
                             e.is_done, e.ab, e.pos, e.z, e.t);
            end
        end
        prev_ab = {enc_a, enc_b};
    end

    task automatic push_ev(bit is_done, int t);
        ev_t e;
        e.is_done = is_done;
        e.ab      = ab_of(exp_pos);
        e.pos     = exp_pos;
        e.z       = z_of(exp_pos);
        e.t       = t;
        sbq.push_back(e);
    endtask

    // Queue n_edges edges (and optionally done) for a command accepted at acc.
    task automatic push_cmd(int steps, int period, int acc, int n_edges, bit with_done);
        int p   = (period == 0) ? 1 : period;
        int dir = (steps < 0) ? -1 : 1;
        for (int k = 1; k <= n_edges; k++) begin
            exp_pos += dir;
            push_ev(1'b0, acc + k * p);
        end
        if (with_done) push_ev(1'b1, (steps == 0) ? acc : acc + n_edges * p + 1);
    endtask

    // Called at negedge+1 while idle; returns at negedge+1 of the accept cycle.
    task automatic cmd(int steps, int period, int n_edges, bit with_done, output int acc);
        acc = cyc + 1;
        push_cmd(steps, period, acc, n_edges, with_done);
        cmd_steps  = STEP_W'(steps);
        cmd_period = PERIOD_W'(period);
        cmd_valid  = 1'b1;
        @(negedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_cyc(int t);
        while (cyc < t) begin @(negedge clk); #1; end
    endtask

    task automatic drain(int budget);
        for (int i = 0; i < budget && sbq.size() != 0; i++) begin @(negedge clk); #1; end
        @(negedge clk); #1;
        chk("scoreboard_drain", sbq.size(), 0);
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_enc_a", enc_a, 0);
        chk("rst_enc_b", enc_b, 0);
        chk("rst_enc_z", enc_z, IDX);
        chk("rst_position", position, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        reset_n = 1'b1;
        exp_pos = 0;
        mon_en  = 1'b1;
    endtask

    initial begin
        #200000;
        n_chk++;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2;
        do_reset();

        // +4 steps, period 3: 10,11,01,00 at +3/6/9/12, done at +13
        cmd(4, 3, 4, 1, a);
        drain(40);
        chk("t1_position", position, 4);
        chk("t1_busy", busy, 0);
        chk("t1_ready", cmd_ready, 1);

        // -2 steps, period 1 from phase 00: 01 then 11
        cmd(-2, 1, 2, 1, a);
        drain(20);
        chk("t2_position", position, 2);

        // zero steps: done only; then period 0 behaves as 1
        cmd(0, 7, 0, 1, a);
        chk("t3_zero_busy", busy, 0);
        drain(10);
        cmd(5, 0, 5, 1, a);
        drain(20);
        chk("t3_position", position, 7);

        // abort while idle does nothing
        abort = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("idle_abort_ready", cmd_ready, 1);
        chk("idle_abort_busy", busy, 0);
        abort = 1'b0;

        // abort together with the final edge: edge and done still happen
        cmd(2, 2, 2, 1, a);
        wait_cyc(a + 3);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        drain(20);
        chk("abort_final_position", position, 9);

        // +100 steps, period 2, abort at the 10th edge
        cmd(100, 2, 10, 0, a);
        wait_cyc(a + 20);
        chk("abort10_position", position, 19);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        chk("abort10_busy", busy, 0);
        chk("abort10_ready", cmd_ready, 1);
        repeat (6) begin @(negedge clk); #1; end
        chk("abort10_frozen_ab", {enc_a, enc_b}, 2'b01);
        chk("abort10_frozen_pos", position, 19);
        drain(5);

        // most negative step count is a real reverse move (aborted after 3 edges)
        cmd(-32768, 1, 3, 0, a);
        chk("maxneg_busy", busy, 1);
        wait_cyc(a + 3);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        chk("maxneg_stopped", busy, 0);
        chk("maxneg_position", position, 16);
        drain(5);

        // index: +16 from reset, then -1
        do_reset();
        cmd(16, 1, 16, 1, a);
        drain(40);
        chk("idx_z_at_16", enc_z, IDX);
        cmd(-1, 1, 1, 1, a);
        drain(10);
        chk("idx_z_at_15", enc_z, 0);
        chk("idx_position", position, 15);

        // cmd_valid held through a 6-edge command
        do_reset();
        cmd_steps  = 16'sd6;
        cmd_period = 16'd2;
        cmd_valid  = 1'b1;
        a1 = cyc + 1;
        push_cmd(6, 2, a1, 6, 1'b1);
        a2 = a1 + 14;
        push_cmd(3, 1, a2, 3, 1'b1);
        @(negedge clk); #1;
        chk("held_ready_low", cmd_ready, 0);
        cmd_steps  = 16'sd3;
        cmd_period = 16'd1;
        wait_cyc(a1 + 6);
        chk("held_busy_mid", busy, 1);
        wait_cyc(a1 + 13);
        chk("held_done_cycle_done", done, 1);
        chk("held_done_cycle_ready", cmd_ready, 1);
        @(negedge clk); #1;
        chk("held_second_accepted", busy, 1);
        cmd_valid = 1'b0;
        drain(20);
        chk("held_position", position, 9);

        // reset in the middle of a run
        cmd(6, 3, 2, 0, a);
        wait_cyc(a + 6);
        chk("midrun_busy", busy, 1);
        do_reset();
        repeat (4) begin @(negedge clk); #1; end
        chk("post_reset_idle_pos", position, 0);
        drain(5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
